// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: scan-out reads (line prime + per-group prefetch) share one
// single-port RAM with a req/ack pixel writer; display reads always win.
module fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int FB_W     = 160,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              de,
  output logic [7:0]        color,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [7:0] LAST_G   = 8'(FB_W - 1);
  localparam logic [9:0] LAST_ROW = 10'(V_ACTIVE - 1);
  localparam logic [9:0] X_END    = 10'(H_ACTIVE);

  typedef enum logic [1:0] {
    TAG_NONE     = 2'b00,
    TAG_PREFETCH = 2'b01,
    TAG_PRIME    = 2'b10
  } tag_e;

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'b00,
    SLOT_PRIME    = 2'b01,
    SLOT_PREFETCH = 2'b10,
    SLOT_WRITE    = 2'b11
  } slot_e;

  // Word address of stored pixel g on the stored row covering screen row `row`;
  // the shift form is the multiply by a 160-pixel stored line.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [9:0] row, input logic [7:0] g);
    logic [16:0] r;
    logic [16:0] sum;
    r   = {9'd0, row[9:2]};
    sum = (r << 7) + (r << 5) + {9'd0, g};
    return sum[ADDR_W-1:0];
  endfunction

  logic [7:0]        cur_r;
  logic [7:0]        nxt_r;
  logic              de_d_r;
  logic              wr_block_r;
  tag_e              tag0_r;
  tag_e              tag1_r;

  logic [7:0]        g_s;
  logic [9:0]        next_row_s;
  logic              in_line_s;
  logic              prime_s;
  logic              prefetch_s;
  logic              write_s;
  logic              swap_s;
  slot_e             slot_s;
  logic [ADDR_W-1:0] slot_addr_s;

  assign g_s        = x[9:2];
  assign in_line_s  = (x < X_END);
  assign next_row_s = (y == LAST_ROW) ? 10'd0 : (y + 10'd1);
  assign prime_s    = de_d_r && !de;
  assign prefetch_s = de && in_line_s && (x[1:0] == 2'd0) && (g_s < LAST_G);
  assign write_s    = wr_req && !wr_block_r;
  // The last group has no successor, so it keeps its pixel through x=4g+3.
  assign swap_s     = de && in_line_s && (x[1:0] == 2'd3) && (g_s != LAST_G);

  // Zero-shift display: cur is already the pixel for the group now on screen.
  assign color = de ? cur_r : 8'h00;

  // Slot arbitration: line-end prime, then prefetch, then the writer.
  always_comb begin
    slot_s      = SLOT_IDLE;
    slot_addr_s = mem_addr;
    if (prime_s) begin
      slot_s      = SLOT_PRIME;
      slot_addr_s = fb_addr(next_row_s, 8'd0);
    end else if (prefetch_s) begin
      slot_s      = SLOT_PREFETCH;
      slot_addr_s = fb_addr(y, g_s + 8'd1);
    end else if (write_s) begin
      slot_s      = SLOT_WRITE;
      slot_addr_s = wr_addr;
    end else begin
      slot_s      = SLOT_IDLE;
      slot_addr_s = mem_addr;
    end
  end

  // Register the granted slot onto the RAM port and track the read tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= {ADDR_W{1'b0}};
      mem_we     <= 1'b0;
      mem_wdata  <= 8'h00;
      wr_ack     <= 1'b0;
      wr_block_r <= 1'b0;
      tag0_r     <= TAG_NONE;
      tag1_r     <= TAG_NONE;
      de_d_r     <= 1'b0;
    end else begin
      mem_addr <= slot_addr_s;
      tag1_r   <= tag0_r;
      de_d_r   <= de;
      case (slot_s)
        SLOT_PRIME: begin
          mem_we     <= 1'b0;
          wr_ack     <= 1'b0;
          wr_block_r <= 1'b0;
          tag0_r     <= TAG_PRIME;
        end
        SLOT_PREFETCH: begin
          mem_we     <= 1'b0;
          wr_ack     <= 1'b0;
          wr_block_r <= 1'b0;
          tag0_r     <= TAG_PREFETCH;
        end
        SLOT_WRITE: begin
          mem_we     <= 1'b1;
          mem_wdata  <= wr_data;
          wr_ack     <= 1'b1;
          wr_block_r <= 1'b1;
          tag0_r     <= TAG_NONE;
        end
        default: begin
          mem_we     <= 1'b0;
          wr_ack     <= 1'b0;
          wr_block_r <= 1'b0;
          tag0_r     <= TAG_NONE;
        end
      endcase
    end
  end

  // Pixel pipeline: returned reads fill cur/nxt, group boundary moves nxt into cur.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_r <= 8'h00;
      nxt_r <= 8'h00;
    end else begin
      if (tag1_r == TAG_PRIME) begin
        cur_r <= mem_rdata;
      end else if (swap_s) begin
        cur_r <= nxt_r;
      end else begin
        cur_r <= cur_r;
      end
      if (tag1_r == TAG_PREFETCH) begin
        nxt_r <= mem_rdata;
      end else begin
        nxt_r <= nxt_r;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural RAM; colour and write grants are
// checked against queued expectations built from a reference image.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x, y;
  logic        de;
  logic [7:0]  color;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  fb_arbiter dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .de(de), .color(color),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, preloaded with a ramp on the first edge.
  logic [7:0] ram [0:32767];
  logic       ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 32768; i++) ram[i] <= i[7:0];
      ram_init <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  logic [7:0]  ref_mem [0:32767];
  logic [22:0] wq[$];
  logic [7:0]  cq[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_cnt = 0;
  bit          need_new = 1'b0;
  bit          sat_mode = 1'b0;
  logic [14:0] sat_addr = 15'd16000;
  logic        prev_de = 1'b0, prev2_de = 1'b0, prev_ack = 1'b0;
  logic [9:0]  prev_x = 10'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_px(input int xx, input int yy);
    return ref_mem[(yy / 4) * 160 + xx / 4];
  endfunction

  // One pixel clock: drive after the edge, compare at the falling edge.
  task automatic cyc(input int xx, input int yy, input logic dd, input bit chk, input bit rst_here);
    logic [7:0]  e;
    logic [22:0] w;
    logic        slot_pf, slot_prime;
    @(posedge clk); #1;
    x  = 10'(xx);
    y  = 10'(yy);
    de = dd;
    if (need_new) begin
      need_new = 1'b0;
      if (sat_mode) begin
        wr_req  = 1'b1;
        wr_addr = sat_addr;
        wr_data = sat_addr[7:0];
        wq.push_back({sat_addr, sat_addr[7:0]});
        sat_addr = sat_addr + 15'd1;
      end else begin
        wr_req = 1'b0;
      end
    end
    if (rst_here) rst = 1'b1;
    else if (chk) cq.push_back(dd ? exp_px(xx, yy) : 8'h00);
    @(negedge clk);
    if (rst_here) begin
      check("rst_color", color, 0);
      check("rst_ack", wr_ack, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      rst = 1'b0;
    end else begin
      if (chk) begin
        e = cq.pop_front();
        check($sformatf("color_x%0d_y%0d", xx, yy), color, e);
      end
      check("we_per_ack", mem_we, wr_ack);
      if (wr_ack === 1'b1) begin
        if (wq.size() == 0) begin
          check("spurious_ack", wr_ack, 0);
        end else begin
          w = wq.pop_front();
          check("wr_addr", mem_addr, w[22:8]);
          check("wr_data", mem_wdata, w[7:0]);
        end
        slot_pf    = prev_de && (prev_x[1:0] == 2'd0) && (prev_x[9:2] < 8'd159);
        slot_prime = prev2_de && !prev_de;
        check("ack_back_to_back", prev_ack, 0);
        check("ack_in_read_slot", slot_pf | slot_prime, 0);
        need_new = 1'b1;
        ack_cnt++;
      end
    end
    prev2_de = prev_de;
    prev_de  = de;
    prev_x   = x;
    prev_ack = wr_ack;
  endtask

  task automatic scan_line(input int row, input bit chk, input int rst_x);
    bit en;
    en = chk;
    for (int xx = 0; xx < 640; xx++) begin
      cyc(xx, row, 1'b1, en && (xx != rst_x), xx == rst_x);
      if (xx == rst_x) en = 1'b0;
    end
    cyc(640, row, 1'b0, chk, 1'b0);
  endtask

  task automatic blank(input int row, input int x0, input int x1);
    for (int xx = x0; xx <= x1; xx++) cyc(xx, row, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic write_once(input logic [14:0] a, input logic [7:0] d);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    wq.push_back({a, d});
    ref_mem[a] = d;
    for (int n = 0; n < 20; n++) begin
      cyc(0, 500, 1'b0, 1'b1, 1'b0);
      if (wq.size() == 0) break;
    end
    check("write_timeout", wq.size(), 0);
    cyc(0, 500, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ref_mem[i] = i[7:0];
    rst = 1'b1; x = 10'd0; y = 10'd0; de = 1'b0;
    wr_req = 1'b1; wr_addr = 15'd0; wr_data = 8'hA5;
    wq.push_back({15'd0, 8'hA5});
    ref_mem[0] = 8'hA5;

    // Reset held with a pending write: everything quiet.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_color", color, 0);
    check("reset_ack", wr_ack, 0);
    check("reset_we", mem_we, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_wdata", mem_wdata, 0);
    rst = 1'b0;

    // Release with de low: grant on the very next edge, exactly once.
    cyc(0, 500, 1'b0, 1'b1, 1'b0);
    check("first_ack", wr_ack, 1);
    check("first_we", mem_we, 1);
    cyc(0, 500, 1'b0, 1'b1, 1'b0);
    check("no_double_grant", wr_ack, 0);

    // Ramp image, row 8 (primed by the end of row 7).
    scan_line(7, 1'b0, -1);
    blank(7, 641, 647);
    scan_line(8, 1'b1, -1);
    blank(8, 641, 647);

    // Write the last word, then read it back at the bottom-right corner.
    write_once(15'd19199, 8'hE3);
    scan_line(475, 1'b0, -1);
    blank(475, 641, 647);
    for (int r = 476; r < 479; r++) begin
      scan_line(r, 1'b1, -1);
      blank(r, 641, 647);
    end
    scan_line(479, 1'b1, -1);
    check("last_prefetch_addr", mem_addr, 19199);
    cyc(641, 479, 1'b0, 1'b1, 1'b0);
    check("prime_wrap_addr", mem_addr, 0);
    check("prime_wrap_we", mem_we, 0);
    blank(479, 642, 647);
    for (int v = 480; v < 490; v++) cyc(0, v, 1'b0, 1'b1, 1'b0);

    // Top of frame shows mem[0]; reset mid-line at x=4g+1, next line recovers.
    scan_line(0, 1'b1, 41);
    blank(0, 641, 647);
    scan_line(1, 1'b1, -1);
    blank(1, 641, 647);

    // Writer saturation over two active lines.
    sat_mode = 1'b1;
    need_new = 1'b1;
    ack_cnt  = 0;
    scan_line(2, 1'b1, -1);
    blank(2, 641, 647);
    scan_line(3, 1'b1, -1);
    blank(3, 641, 647);
    sat_mode = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (wq.size() == 0 && wr_req == 1'b0) break;
      cyc(0, 500, 1'b0, 1'b1, 1'b0);
    end
    check("sat_drain", wq.size(), 0);
    check("sat_ack_count", (ack_cnt >= 500) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
